// File: rtl/reg_file_pkg.sv
// Shared datapath constants for the ALU, the control unit and the register file.
package reg_file_pkg;

    localparam int unsigned    DATA_W   = 32;
    localparam int unsigned    ADDR_W   = 5;
    localparam int unsigned    REG_ZERO = 0;
    localparam int unsigned    REG_SP   = 29;
    localparam logic [31:0]    SP_INIT  = 32'd128;

endpackage : reg_file_pkg

// File: rtl/reg_file_if.sv
// Register-file access bundle: two read ports and one write port.
interface reg_file_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);

    logic [ADDR_W-1:0] RSaddr;
    logic [ADDR_W-1:0] RTaddr;
    logic [ADDR_W-1:0] RDaddr;
    logic [DATA_W-1:0] RDdata;
    logic              RegWrite;
    logic [DATA_W-1:0] RSdata;
    logic [DATA_W-1:0] RTdata;

    modport master (
        output RSaddr, RTaddr, RDaddr, RDdata, RegWrite,
        input  RSdata, RTdata
    );

    modport slave (
        input  RSaddr, RTaddr, RDaddr, RDdata, RegWrite,
        output RSdata, RTdata
    );

endinterface : reg_file_if

// File: rtl/reg_file.sv
// 2R1W register file: r0 hard-wired to zero, r29 resets to SP_INIT,
// optional same-cycle write-to-read forwarding.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned       DATA_W  = reg_file_pkg::DATA_W,
    parameter int unsigned       ADDR_W  = reg_file_pkg::ADDR_W,
    parameter logic [DATA_W-1:0] SP_INIT = reg_file_pkg::SP_INIT,
    parameter bit                BYPASS  = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] RSaddr_i,
    input  logic [ADDR_W-1:0] RTaddr_i,
    input  logic [ADDR_W-1:0] RDaddr_i,
    input  logic [DATA_W-1:0] RDdata_i,
    input  logic              RegWrite_i,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              wr_en;

    assign wr_en = RegWrite_i && (RDaddr_i != ADDR_W'(REG_ZERO));

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[RDaddr_i] = RDdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == REG_SP) ? SP_INIT : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Shared per-port read path: reset gate, r0 gate, then forward-or-stored.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst_n,
        input logic [ADDR_W-1:0] ra,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd,
        input logic [DATA_W-1:0] stored
    );
        if (!rst_n)                           return '0;
        if (ra == ADDR_W'(REG_ZERO))          return '0;
        if (BYPASS && we && (wa == ra))       return wd;
        return stored;
    endfunction

    always_comb begin
        RSdata_o = read_port(rst_i, RSaddr_i, wr_en, RDaddr_i, RDdata_i, regs_q[RSaddr_i]);
        RTdata_o = read_port(rst_i, RTaddr_i, wr_en, RDaddr_i, RDdata_i, regs_q[RTaddr_i]);
    end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Bench for reg_file: forwarding and non-forwarding instances share one stimulus
// stream and are compared with an array-based reference model.
module tb_reg_file;
    import reg_file_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    logic [31:0] rs_nb, rt_nb;

    reg_file #(.BYPASS(1'b1)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .RSaddr_i(bus.RSaddr), .RTaddr_i(bus.RTaddr),
        .RDaddr_i(bus.RDaddr), .RDdata_i(bus.RDdata), .RegWrite_i(bus.RegWrite),
        .RSdata_o(bus.RSdata), .RTdata_o(bus.RTdata)
    );

    reg_file #(.BYPASS(1'b0)) dut_nb (
        .clk_i(clk), .rst_i(rst_n),
        .RSaddr_i(bus.RSaddr), .RTaddr_i(bus.RTaddr),
        .RDaddr_i(bus.RDaddr), .RDdata_i(bus.RDdata), .RegWrite_i(bus.RegWrite),
        .RSdata_o(rs_nb), .RTdata_o(rt_nb)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] mem [32];
    logic [31:0] alu_res;

    function automatic logic [31:0] ref_read(input logic [4:0] addr, input bit fwd);
        if (rst_n !== 1'b1) return 32'h0;
        if (addr == 5'd0) return 32'h0;
        if (fwd && bus.RegWrite === 1'b1 && bus.RDaddr == addr) return bus.RDdata;
        return mem[addr];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/rs"},    bus.RSdata, ref_read(bus.RSaddr, 1'b1));
        check({tag, "/rt"},    bus.RTdata, ref_read(bus.RTaddr, 1'b1));
        check({tag, "/rs_nb"}, rs_nb,      ref_read(bus.RSaddr, 1'b0));
        check({tag, "/rt_nb"}, rt_nb,      ref_read(bus.RTaddr, 1'b0));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = (i == 29) ? SP_INIT : 32'h0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input string tag, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
        bus.RegWrite = we; bus.RDaddr = wa; bus.RDdata = wd;
        bus.RSaddr = ra; bus.RTaddr = rb;
        #1 check_all({tag, "/pre"});
        @(posedge clk);
        if (rst_n === 1'b1 && we === 1'b1 && wa != 5'd0) mem[wa] = wd;
        #1 check_all({tag, "/post"});
        @(negedge clk);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 32; i++)
            cycle(tag, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        bus.RegWrite = 1'b0; bus.RDaddr = '0; bus.RDdata = '0;
        bus.RSaddr = 5'd29; bus.RTaddr = 5'd1;
        @(negedge clk);
        check("reset_out_rs", bus.RSdata, 32'h0);
        check("reset_out_rt", rt_nb, 32'h0);
        rst_n = 1'b1;
        read_all("reset_vals");
        check("sp_init_literal", mem[29], 32'h0000_0080);

        cycle("wr5", 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
        cycle("rd5", 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        check("rd5_lit", bus.RSdata, 32'hDEAD_BEEF);

        cycle("wr0", 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        cycle("rd0", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        cycle("byp7", 1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd5);
        cycle("rd7", 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

        cycle("alu_r1", 1'b1, 5'd1, 32'd7, 5'd0, 5'd0);
        cycle("alu_r2", 1'b1, 5'd2, 32'd5, 5'd0, 5'd0);
        bus.RSaddr = 5'd1; bus.RTaddr = 5'd2; bus.RegWrite = 1'b0;
        #1 alu_res = bus.RSdata - bus.RTdata;
        check("alu_zero", {31'h0, alu_res == 32'h0}, 32'h0);
        @(negedge clk);
        cycle("alu_wb", 1'b1, 5'd3, alu_res, 5'd0, 5'd0);
        cycle("alu_rd3", 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        check("alu_rd3_lit", bus.RSdata, 32'h0000_0002);

        for (int i = 0; i < 300; i++)
            cycle("rand", 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                  5'($urandom), 5'($urandom));

        cycle("x_addr", 1'b0, 5'bxxxxx, 32'hA5A5_A5A5, 5'd5, 5'd7);
        read_all("after_x");

        bus.RegWrite = 1'b1; bus.RDaddr = 5'd9; bus.RDdata = 32'h9999_9999;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("mid_reset");
        @(posedge clk);
        #1 check_all("mid_reset_edge");
        @(negedge clk);
        rst_n = 1'b1;
        read_all("after_mid_reset");

        bus.RegWrite = 1'b1; bus.RDaddr = 5'd3; bus.RDdata = 32'h55;
        bus.RSaddr = 5'd3; bus.RTaddr = 5'd29;
        #4 rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 check_all("race_edge");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("race_rd3", 1'b0, 5'd0, 32'h0, 5'd3, 5'd29);
        check("race_rd3_lit", bus.RSdata, 32'h0);

        cycle("first_wr", 1'b1, 5'd4, 32'hCAFE_F00D, 5'd4, 5'd4);
        cycle("first_rd", 1'b0, 5'd0, 32'h0, 5'd4, 5'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_reg_file

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32: register and data width in bits.
REQ-002 Parameter ADDR_W, default 5: address width, giving 2^ADDR_W = 32 registers.
REQ-003 Parameter SP_INIT, default 32'd128: reset value of the stack-pointer register (index 29).
REQ-004 Parameter BYPASS, default 1: 1 enables write-to-read forwarding; 0 disables it.
REQ-005 Port clk_i, input, 1: the single clock; all register updates occur on its rising edge.
REQ-006 Port rst_i, input, 1: reset, asynchronous and active-low.
REQ-007 Port RSaddr_i, input, ADDR_W: read port 1 address (ALU src1 operand).
REQ-008 Port RTaddr_i, input, ADDR_W: read port 2 address (ALU src2 operand).
REQ-009 Port RDaddr_i, input, ADDR_W: write port address.
REQ-010 Port RDdata_i, input, DATA_W: write data (ALU result_o or load data).
REQ-011 Port RegWrite_i, input, 1: write enable for the current cycle.
REQ-012 Port RSdata_o, output, DATA_W: read port 1 data, driven to ALU src1_i.
REQ-013 Port RTdata_o, output, DATA_W: read port 2 data, driven to ALU src2_i.

Function
REQ-014 The block SHALL write RDdata_i into register RDaddr_i at each rising clk_i edge where RegWrite_i=1, rst_i=1 and RDaddr_i!=0.
REQ-015 Register 0 SHALL always read as zero; any write to register 0 SHALL be discarded.
REQ-016 Reads SHALL be combinational, with zero cycles of latency from address to data.
REQ-017 With BYPASS=1: if RegWrite_i=1, RDaddr_i!=0 and RDaddr_i equals a read address, that port SHALL output RDdata_i in the same cycle.
REQ-018 With BYPASS=0: a read SHALL return the stored value, so new data becomes visible the cycle after the write edge.
REQ-019 Both read ports SHALL operate independently; identical RS and RT addresses SHALL return identical data.
REQ-020 Simultaneous read and write of different registers SHALL leave the read unaffected.
REQ-021 When RegWrite_i=0, stored contents SHALL hold indefinitely.
REQ-022 While rst_i=0, both read outputs SHALL be forced to 0, matching the ALU's result_o=0 during reset.
REQ-023 X or Z on RDaddr_i while RegWrite_i=0 SHALL NOT corrupt any register.

Reset
REQ-024 On the falling edge of rst_i, immediately and without a clock, all registers SHALL clear to 0, except register 29, which SHALL load SP_INIT.
REQ-025 Writes SHALL be ignored while rst_i=0; a write edge coinciding with reset assertion SHALL lose to reset.
REQ-026 The first write SHALL take effect on the first rising clk_i edge after rst_i returns to 1.
REQ-027 Reset asserted mid-operation SHALL discard all prior contents and restore the values in REQ-024.

Structure
REQ-028 A shared package SHALL hold DATA_W, ADDR_W, the REG_ZERO=0 and REG_SP=29 index constants, and SP_INIT; the ALU, the control unit and reg_file SHALL import this package.
REQ-029 Storage SHALL be a single 32 x DATA_W array inside reg_file, with no sub-module.
REQ-030 Bypass logic SHALL be one shared compare-and-mux function applied to each read port.

Verification
REQ-031 Reset check: assert rst_i=0 mid-cycle, then read all 32 addresses -> 0 everywhere except reg29=0x00000080; outputs are 0 during reset.
REQ-032 Write/read check: write reg5=0xDEADBEEF, then the next cycle set RSaddr=5, RTaddr=5 -> both outputs read 0xDEADBEEF.
REQ-033 Zero-register check: write reg0=0xFFFFFFFF -> reading reg0 returns 0x00000000, both in the same cycle and the next.
REQ-034 Bypass check (BYPASS=1): RegWrite=1, RD=7, data=0x12345678, RS=7 in the same cycle -> RSdata_o=0x12345678 before the edge; with BYPASS=0, it shows the old value.
REQ-035 Reset-race check: write reg3=0x55 with rst_i falling 1 ns before the clock edge -> reg3 reads 0 after release.
REQ-036 ALU loopback check: reg1=7, reg2=5 feed the ALU with subtract (ctrl 0110) -> result 2 is written to reg3; a read of reg3 returns 0x00000002 and zero_o=0.
